imem_program_writer: RTL and testbench
======================================

# imem_program_writer

Loads a program into instruction memory. A host or test harness supplies decoded instruction fields. The block packs each set of fields into the 9-bit instruction word that the control unit decodes (opcode in bits [8:4], operand in bits [3:0]). It buffers the words in a small FIFO and writes them to sequential instruction-memory addresses until it writes a `halt`. It sits between the boot/debug port and the instruction memory, and is the encoding counterpart of the control unit's decoder.

## Interface
- `ADDR_W`, default 8: instruction-memory address width.
- `FIFO_DEPTH`, default 4: encoded-word buffer depth, a power of 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse. Begins a load at address 0.
- `in_valid` in 1: field bundle valid.
- `in_ready` out 1: block accepts the bundle this cycle.
- `in_opcode` in 5: instruction opcode.
- `in_ra` in 2: first register field. Becomes operand[3:2].
- `in_rb` in 2: second register field. Becomes operand[1:0].
- `in_imm` in 4: immediate, used by `seti` only.
- `in_sign` in 1: jump sign, used by `rsAdr` only.
- `imem_we` out 1: write strobe.
- `imem_ready` in 1: memory accepts the write this cycle.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out 9: encoded instruction.
- `done` out 1: load complete. Held until the next `start` or reset.
- `overflow` out 1: address space exhausted before `halt`.
- `err_count` out 8: count of illegal opcodes dropped. Saturates at 255.

## Operation
- **States:** IDLE, LOAD, DRAIN, DONE.
  - IDLE → LOAD on `start`.
  - LOAD → DRAIN when a `halt` is accepted, or when the last address is consumed.
  - DRAIN → DONE when the FIFO is empty and no write is pending.
  - `start` in DONE → LOAD. It clears `done`, `overflow`, `err_count`, the address and the FIFO.
  - `start` in LOAD or DRAIN is ignored.
- **Encoding** (combinational on the accepted bundle; word = {opcode, operand}):
  - `seti` (00110): operand = `in_imm`.
  - `rsAdr` (00101): operand = {3'b000, `in_sign`}.
  - `halt` (11010), `jump` (11000): operand = 4'b0000.
  - `mvAdr` (00100), `mvMath` (00111), `mvCnt` (01100), `rsCnt` (01110), `zeroReg` (11001): operand = {2'b00, `in_rb`}.
  - All other legal opcodes 00000–11010: operand = {`in_ra`, `in_rb`}.
- **Illegal opcodes** 11011–11111: the bundle is accepted (handshake completes), not pushed, and `err_count` increments.
- `in_ready` = (state == LOAD) && FIFO not full && no `halt` accepted yet && address budget not exhausted.
- **Address budget:** the block counts pushed words. When 2^ADDR_W words have been pushed without a `halt`, it sets `overflow` and goes to DRAIN. Address wrap to 0 never occurs.
- **Writer:** while the FIFO is non-empty, `imem_we`=1 with head data and the current address. On `imem_we && imem_ready` it pops and increments `imem_addr`. `imem_wdata`/`imem_addr` are held stable while `imem_ready`=0.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.

## Timing
- **Reset values:** state IDLE; `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `done` 0, `overflow` 0, `err_count` 0; FIFO empty.
- **Latency:** the bundle is accepted at edge N. `imem_we` is asserted for it in cycle N+1 if the FIFO was empty.
- **Throughput:** one word per cycle with `imem_ready` tied high.
- `done` rises the cycle after the final write handshake.
- Reset mid-load: all state returns to reset values at the next edge. Partial memory contents are left as written.

## Structure
- Shared package `isa_pkg`: 5-bit opcode localparams (same values as the control unit), `INSTR_W`=9, `OPC_W`=5, and the illegal-opcode range check function. The control unit imports the same package.
- One sub-module, `sync_fifo`: parameterized width/depth, with push, pop, full, empty, and head data.
- Encoder and state machine live in the top module.

## Test plan
- `start`; bundle add ra=01 rb=10; then `halt`; `imem_ready`=1 → writes 0x006 @0, 0x1A0 @1; `done` rises one cycle after the second write.
- `seti` imm=0xA, `rsAdr` sign=1, `halt` → writes 0x06A @0, 0x051 @1, 0x1A0 @2.
- Opcode 11011 between two adds → `err_count`=1; only 2 adds plus `halt` are written, at addresses 0–2 with no gap.
- `imem_ready` held 0 for 10 cycles during a stream of 6 bundles → `in_ready` drops after 4 accepted; addr/data stable; all 6 written in order once released.
- ADDR_W=2, 5 adds and no `halt` → 4 writes @0–3; the 5th is not accepted; `overflow`=1 and `done`=1.
- Assert `rst_n`=0 mid-load, then `start` → `imem_addr` restarts at 0; FIFO is empty; flags are clear.

Source files
------------

// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : isa_pkg
//  Brief    : Instruction-set constants shared by the program writer and the
//             control unit: field widths, opcode values, legality check and
//             the loader state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package isa_pkg;

    localparam int OPC_W     = 5;
    localparam int OPERAND_W = 4;
    localparam int INSTR_W   = OPC_W + OPERAND_W;

    // Opcode map (identical values to the control-unit decoder)
    localparam logic [OPC_W-1:0] OPC_ADD        = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_MVADR      = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_RSADR      = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SETI       = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_MVMATH     = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_MVCNT      = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_RSCNT      = 5'b01110;
    localparam logic [OPC_W-1:0] OPC_JUMP       = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_ZEROREG    = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_HALT       = 5'b11010;
    localparam logic [OPC_W-1:0] OPC_LAST_LEGAL = 5'b11010;

    // Loader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    // Everything above halt (11011..11111) is unassigned and must be dropped
    function automatic logic is_illegal_opc(input logic [OPC_W-1:0] opc);
        return (opc > OPC_LAST_LEGAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_program_writer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with simultaneous push/pop, full/empty flags,
//             occupancy count and a combinational head-of-queue output.
//             DEPTH must be a power of two so the pointers wrap naturally.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Pointer and occupancy bookkeeping; clear wins over any push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the entry is unoccupied
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_program_writer.sv
`default_nettype none
// ============================================================================
//  Module   : imem_program_writer
//  Brief    : Packs decoded instruction fields into 9-bit words, buffers them
//             and writes them to consecutive instruction-memory addresses
//             from 0 until a halt has been written or the address space is
//             exhausted.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_program_writer
    import isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         in_opcode,
    input  logic [1:0]         in_ra,
    input  logic [1:0]         in_rb,
    input  logic [3:0]         in_imm,
    input  logic               in_sign,
    output logic               imem_we,
    input  logic               imem_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [8:0]         imem_wdata,
    output logic               done,
    output logic               overflow,
    output logic [7:0]         err_count
);

    localparam int                CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  FIFO_ONE   = CNT_W'(1);
    // Number of words that fit in the address space (2^ADDR_W)
    localparam logic [ADDR_W:0]   ADDR_SPACE = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   PUSH_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    load_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     push_cnt_q, push_cnt_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          err_count_q, err_count_d;

    logic [OPERAND_W-1:0] operand;
    logic [INSTR_W-1:0]   enc_word;
    logic                 accept;
    logic                 opc_illegal;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_clear;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [INSTR_W-1:0]   fifo_head;
    logic [CNT_W-1:0]     fifo_count;

    // Field packing: operand layout depends on which fields the opcode uses
    always_comb begin
        operand = {in_ra, in_rb};
        case (in_opcode)
            OPC_SETI:  operand = in_imm;
            OPC_RSADR: operand = {3'b000, in_sign};
            OPC_HALT,
            OPC_JUMP:  operand = 4'b0000;
            OPC_MVADR,
            OPC_MVMATH,
            OPC_MVCNT,
            OPC_RSCNT,
            OPC_ZEROREG: operand = {2'b00, in_rb};
            default:   operand = {in_ra, in_rb};
        endcase
        enc_word = {in_opcode, operand};
    end

    // Leaving LOAD on halt or budget exhaustion also closes in_ready
    assign in_ready    = (state_q == ST_LOAD) && !fifo_full &&
                         (push_cnt_q != ADDR_SPACE);
    assign accept      = in_valid && in_ready;
    assign opc_illegal = is_illegal_opc(in_opcode);
    assign fifo_push   = accept && !opc_illegal;
    assign fifo_pop    = imem_we && imem_ready;

    assign imem_we    = !fifo_empty;
    assign imem_wdata = fifo_empty ? '0 : fifo_head;
    assign imem_addr  = addr_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign err_count  = err_count_q;

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (enc_word),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    // Next-state logic for sequencing, address, budget and status flags
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        push_cnt_d  = push_cnt_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        err_count_d = err_count_q;
        fifo_clear  = 1'b0;

        // Address only advances on a completed write; it saturates rather
        // than wrapping after the last location has been written
        if (fifo_pop && (addr_q != ADDR_MAX)) begin
            addr_d = addr_q + ADDR_ONE;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    addr_d      = '0;
                    push_cnt_d  = '0;
                    done_d      = 1'b0;
                    overflow_d  = 1'b0;
                    err_count_d = '0;
                    fifo_clear  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (opc_illegal) begin
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end else begin
                        push_cnt_d = push_cnt_q + PUSH_ONE;
                        if (in_opcode == OPC_HALT) begin
                            state_d = ST_DRAIN;
                        end else if ((push_cnt_q + PUSH_ONE) == ADDR_SPACE) begin
                            state_d    = ST_DRAIN;
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Finish on the edge that retires the final word so that
                // done is visible in the very next cycle
                if (fifo_empty || ((fifo_count == FIFO_ONE) && fifo_pop)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            push_cnt_q  <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            push_cnt_q  <= push_cnt_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_program_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_program_writer
//  Brief    : Self-checking bench for imem_program_writer (ADDR_W=8 and
//             ADDR_W=2 instances) with a program-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_program_writer;

    localparam int AW  = 8;
    localparam int AW2 = 2;

    localparam logic [4:0] T_ADD     = 5'b00000;
    localparam logic [4:0] T_MVADR   = 5'b00100;
    localparam logic [4:0] T_RSADR   = 5'b00101;
    localparam logic [4:0] T_SETI    = 5'b00110;
    localparam logic [4:0] T_MVMATH  = 5'b00111;
    localparam logic [4:0] T_MVCNT   = 5'b01100;
    localparam logic [4:0] T_RSCNT   = 5'b01110;
    localparam logic [4:0] T_JUMP    = 5'b11000;
    localparam logic [4:0] T_ZEROREG = 5'b11001;
    localparam logic [4:0] T_HALT    = 5'b11010;

    typedef struct packed {
        logic [4:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [3:0] imm;
        logic       sign;
    } bundle_t;

    typedef struct packed {
        bundle_t    b;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start2, in_valid, in_valid2, imem_ready;
    logic [4:0] in_opcode;
    logic [1:0] in_ra, in_rb;
    logic [3:0] in_imm;
    logic       in_sign;

    logic           in_ready, imem_we, done, overflow;
    logic [AW-1:0]  imem_addr;
    logic [8:0]     imem_wdata;
    logic [7:0]     err_count;
    logic           in_ready2, imem_we2, done2, overflow2;
    logic [AW2-1:0] imem_addr2;
    logic [8:0]     imem_wdata2;
    logic [7:0]     err_count2;

    imem_program_writer #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_opcode(in_opcode), .in_ra(in_ra),
        .in_rb(in_rb), .in_imm(in_imm), .in_sign(in_sign),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .done(done), .overflow(overflow),
        .err_count(err_count)
    );

    imem_program_writer #(.ADDR_W(AW2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
        .in_ready(in_ready2), .in_opcode(in_opcode), .in_ra(in_ra),
        .in_rb(in_rb), .in_imm(in_imm), .in_sign(in_sign),
        .imem_we(imem_we2), .imem_ready(imem_ready), .imem_addr(imem_addr2),
        .imem_wdata(imem_wdata2), .done(done2), .overflow(overflow2),
        .err_count(err_count2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    logic [31:0] wa_q[$], wd_q[$], wa2_q[$], wd2_q[$];
    bundle_t     prog_q[$];
    logic [8:0]  exp_q[$];
    int          exp_err, exp_nacc;
    bit          exp_ovf;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
        end
    endtask

    // Memory-side ready pattern
    initial begin
        imem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       imem_ready = 1'b1;
                1:       imem_ready = 1'($urandom_range(0, 1));
                default: imem_ready = 1'b0;
            endcase
        end
    end

    // Write capture and stall-stability monitor
    bit          hold_v = 0;
    logic [31:0] hold_addr, hold_data;
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_v) begin
                check("stall", "we", {31'd0, imem_we}, 32'd1);
                check("stall", "addr", 32'(imem_addr), hold_addr);
                check("stall", "data", 32'(imem_wdata), hold_data);
            end
            hold_v    = imem_we && !imem_ready;
            hold_addr = 32'(imem_addr);
            hold_data = 32'(imem_wdata);
            if (imem_we && imem_ready) begin
                wa_q.push_back(32'(imem_addr));
                wd_q.push_back(32'(imem_wdata));
            end
            if (imem_we2 && imem_ready) begin
                wa2_q.push_back(32'(imem_addr2));
                wd2_q.push_back(32'(imem_wdata2));
            end
        end else begin
            hold_v = 0;
        end
    end

    function automatic bundle_t mk(input logic [4:0] op, input logic [1:0] ra,
                                   input logic [1:0] rb, input logic [3:0] imm,
                                   input logic sign);
        bundle_t b;
        b.op = op; b.ra = ra; b.rb = rb; b.imm = imm; b.sign = sign;
        return b;
    endfunction

    // Instruction word from the field rules
    function automatic logic [8:0] ref_encode(input bundle_t b);
        logic [3:0] opnd;
        if (b.op == T_SETI)                          opnd = b.imm;
        else if (b.op == T_RSADR)                    opnd = {3'b000, b.sign};
        else if (b.op == T_HALT || b.op == T_JUMP)   opnd = 4'd0;
        else if (b.op inside {T_MVADR, T_MVMATH, T_MVCNT, T_RSCNT, T_ZEROREG})
                                                     opnd = {2'b00, b.rb};
        else                                         opnd = {b.ra, b.rb};
        return {b.op, opnd};
    endfunction

    // Program-level model: which bundles get taken, what lands in memory
    task automatic model(input int aw);
        bit stopped = 0;
        exp_q.delete(); exp_err = 0; exp_ovf = 0; exp_nacc = 0;
        foreach (prog_q[i]) begin
            if (stopped) break;
            exp_nacc++;
            if (prog_q[i].op >= 5'd27) begin
                if (exp_err < 255) exp_err++;
            end else begin
                exp_q.push_back(ref_encode(prog_q[i]));
                if (prog_q[i].op == T_HALT) stopped = 1;
                else if (exp_q.size() == (1 << aw)) begin
                    exp_ovf = 1; stopped = 1;
                end
            end
        end
    endtask

    task automatic pulse_start(input int which);
        wa_q.delete(); wd_q.delete(); wa2_q.delete(); wd2_q.delete();
        if (which == 0) start = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic send(input int which, input bundle_t b, input int budget,
                        output bit acc);
        acc = 0;
        in_opcode = b.op; in_ra = b.ra; in_rb = b.rb; in_imm = b.imm; in_sign = b.sign;
        if (which == 0) in_valid = 1'b1; else in_valid2 = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0) ? in_ready : in_ready2) acc = 1;
            @(posedge clk); #1;
            if (acc) break;
        end
        in_valid = 1'b0; in_valid2 = 1'b0;
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((which == 0) ? done : done2) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic compare_all(input string tag, input int which);
        int n;
        n = (which == 0) ? wd_q.size() : wd2_q.size();
        check(tag, "write count", 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check(tag, $sformatf("data[%0d]", i),
                  (which == 0) ? wd_q[i] : wd2_q[i], 32'(exp_q[i]));
            check(tag, $sformatf("addr[%0d]", i),
                  (which == 0) ? wa_q[i] : wa2_q[i], 32'(i));
        end
        check(tag, "done", {31'd0, (which == 0) ? done : done2}, 32'd1);
        check(tag, "overflow", {31'd0, (which == 0) ? overflow : overflow2}, 32'(exp_ovf));
        check(tag, "err_count", 32'((which == 0) ? err_count : err_count2), 32'(exp_err));
    endtask

    task automatic run_and_check(input string tag, input int which, input int aw);
        bit acc;
        model(aw);
        pulse_start(which);
        for (int i = 0; i < exp_nacc; i++) begin
            send(which, prog_q[i], 60, acc);
            check(tag, $sformatf("accept[%0d]", i), {31'd0, acc}, 32'd1);
        end
        if (exp_nacc < prog_q.size()) begin
            send(which, prog_q[exp_nacc], 20, acc);
            check(tag, "refused", {31'd0, acc}, 32'd0);
        end
        wait_done(which);
        compare_all(tag, which);
    endtask

    task automatic check_reset(input string tag);
        check(tag, "in_ready", {31'd0, in_ready}, 32'd0);
        check(tag, "imem_we", {31'd0, imem_we}, 32'd0);
        check(tag, "imem_addr", 32'(imem_addr), 32'd0);
        check(tag, "imem_wdata", 32'(imem_wdata), 32'd0);
        check(tag, "done", {31'd0, done}, 32'd0);
        check(tag, "overflow", {31'd0, overflow}, 32'd0);
        check(tag, "err_count", 32'(err_count), 32'd0);
        check(tag, "dut2 state", {in_ready2, imem_we2, done2, overflow2, 22'd0, err_count2}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t    tbl[14];
    bundle_t hlt;
    bit      acc;

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        in_opcode = '0; in_ra = '0; in_rb = '0; in_imm = '0; in_sign = 1'b0;
        hlt = mk(T_HALT, 2'd3, 2'd3, 4'hF, 1'b1);

        tbl[0]  = '{mk(T_ADD,     2'd1, 2'd2, 4'h0, 1'b0), 9'h006};
        tbl[1]  = '{mk(T_SETI,    2'd3, 2'd3, 4'hA, 1'b1), 9'h06A};
        tbl[2]  = '{mk(T_RSADR,   2'd3, 2'd3, 4'hF, 1'b1), 9'h051};
        tbl[3]  = '{mk(T_JUMP,    2'd2, 2'd1, 4'h5, 1'b1), 9'h180};
        tbl[4]  = '{mk(T_MVADR,   2'd3, 2'd2, 4'hF, 1'b0), 9'h042};
        tbl[5]  = '{mk(T_MVMATH,  2'd1, 2'd3, 4'h0, 1'b1), 9'h073};
        tbl[6]  = '{mk(T_MVCNT,   2'd2, 2'd1, 4'h3, 1'b0), 9'h0C1};
        tbl[7]  = '{mk(T_RSCNT,   2'd3, 2'd0, 4'hC, 1'b1), 9'h0E0};
        tbl[8]  = '{mk(T_ZEROREG, 2'd1, 2'd2, 4'h7, 1'b1), 9'h192};
        tbl[9]  = '{mk(5'b00001,  2'd2, 2'd3, 4'h0, 1'b0), 9'h01B};
        tbl[10] = '{mk(5'b10101,  2'd1, 2'd1, 4'hF, 1'b1), 9'h155};
        tbl[11] = '{mk(5'b01101,  2'd3, 2'd3, 4'h0, 1'b0), 9'h0DF};
        tbl[12] = '{mk(T_SETI,    2'd3, 2'd3, 4'h0, 1'b1), 9'h060};
        tbl[13] = '{mk(T_RSADR,   2'd3, 2'd3, 4'hF, 1'b0), 9'h050};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // add + halt: latency, ordering and done timing
        prog_q.delete();
        prog_q.push_back(mk(T_ADD, 2'd1, 2'd2, 4'h0, 1'b0));
        prog_q.push_back(hlt);
        model(AW);
        pulse_start(0);
        send(0, prog_q[0], 10, acc);
        check("t1", "accept add", {31'd0, acc}, 32'd1);
        @(negedge clk);
        check("t1", "we next cycle", {31'd0, imem_we}, 32'd1);
        check("t1", "first word", 32'(imem_wdata), 32'h006);
        check("t1", "first addr", 32'(imem_addr), 32'd0);
        @(posedge clk); #1;
        send(0, hlt, 10, acc);
        @(negedge clk);
        check("t1", "halt word", 32'(imem_wdata), 32'h1A0);
        check("t1", "halt addr", 32'(imem_addr), 32'd1);
        check("t1", "done before", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1", "done after", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        wait_done(0);
        compare_all("t1", 0);

        // seti / rsAdr / halt with fixed expected words
        prog_q.delete();
        prog_q.push_back(mk(T_SETI, 2'd0, 2'd0, 4'hA, 1'b0));
        prog_q.push_back(mk(T_RSADR, 2'd2, 2'd1, 4'h3, 1'b1));
        prog_q.push_back(hlt);
        run_and_check("t2", 0, AW);
        if (wd_q.size() == 3) begin
            check("t2", "w0", wd_q[0], 32'h06A);
            check("t2", "w1", wd_q[1], 32'h051);
            check("t2", "w2", wd_q[2], 32'h1A0);
        end else check("t2", "size", 32'(wd_q.size()), 32'd3);

        // illegal opcode between two adds
        prog_q.delete();
        prog_q.push_back(mk(T_ADD, 2'd0, 2'd1, 4'h0, 1'b0));
        prog_q.push_back(mk(5'b11011, 2'd3, 2'd3, 4'hF, 1'b1));
        prog_q.push_back(mk(T_ADD, 2'd2, 2'd3, 4'h0, 1'b0));
        prog_q.push_back(hlt);
        run_and_check("t3", 0, AW);
        check("t3", "err_count", 32'(err_count), 32'd1);
        check("t3", "writes", 32'(wd_q.size()), 32'd3);

        // encoder table
        foreach (tbl[i]) begin
            prog_q.delete();
            prog_q.push_back(tbl[i].b);
            prog_q.push_back(hlt);
            run_and_check($sformatf("tbl%0d", i), 0, AW);
            if (wd_q.size() > 0) check($sformatf("tbl%0d", i), "word", wd_q[0], 32'(tbl[i].exp));
        end

        // memory stall: six bundles, FIFO fills after four; stray start ignored
        prog_q.delete();
        for (int i = 0; i < 6; i++)
            prog_q.push_back(mk(T_ADD, 2'(i >> 2), 2'(i), 4'h0, 1'b0));
        prog_q.push_back(hlt);
        model(AW);
        ready_mode = 2;
        @(posedge clk); #1;
        pulse_start(0);
        for (int i = 0; i < 4; i++) begin
            send(0, prog_q[i], 10, acc);
            check("t4", $sformatf("accept[%0d]", i), {31'd0, acc}, 32'd1);
        end
        in_opcode = prog_q[4].op; in_ra = prog_q[4].ra; in_rb = prog_q[4].rb;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4", "in_ready low", {31'd0, in_ready}, 32'd0);
            check("t4", "stall addr", 32'(imem_addr), 32'd0);
            @(posedge clk); #1;
            start = (i == 4);
        end
        start = 1'b0;
        in_valid = 1'b0;
        ready_mode = 0;
        for (int i = 4; i < 7; i++) begin
            send(0, prog_q[i], 20, acc);
            check("t4", $sformatf("accept[%0d]", i), {31'd0, acc}, 32'd1);
        end
        wait_done(0);
        compare_all("t4", 0);

        // address budget on the ADDR_W=2 instance
        prog_q.delete();
        for (int i = 0; i < 5; i++)
            prog_q.push_back(mk(T_ADD, 2'd1, 2'(i), 4'h0, 1'b0));
        run_and_check("ovf", 1, AW2);
        check("ovf", "overflow", {31'd0, overflow2}, 32'd1);

        // halt as the very last word of the space is not an overflow
        prog_q.delete();
        for (int i = 0; i < 3; i++)
            prog_q.push_back(mk(T_ADD, 2'd2, 2'(i), 4'h0, 1'b0));
        prog_q.push_back(hlt);
        run_and_check("fit", 1, AW2);

        // error counter saturation
        prog_q.delete();
        for (int i = 0; i < 260; i++)
            prog_q.push_back(mk(5'(27 + (i % 5)), 2'd1, 2'd1, 4'h1, 1'b0));
        prog_q.push_back(hlt);
        run_and_check("sat", 0, AW);

        // reset in the middle of a load
        ready_mode = 2;
        @(posedge clk); #1;
        pulse_start(0);
        send(0, mk(5'b11111, 2'd0, 2'd0, 4'h0, 1'b0), 10, acc);
        send(0, mk(T_ADD, 2'd3, 2'd3, 4'h0, 1'b0), 10, acc);
        send(0, mk(T_ADD, 2'd1, 2'd0, 4'h0, 1'b0), 10, acc);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk); #1;
        prog_q.delete();
        prog_q.push_back(mk(T_MVCNT, 2'd3, 2'd2, 4'h0, 1'b0));
        prog_q.push_back(hlt);
        run_and_check("postrst", 0, AW);

        // randomized programs with random memory back-pressure
        ready_mode = 1;
        for (int r = 0; r < 20; r++) begin
            int len;
            prog_q.delete();
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                bundle_t b;
                if ($urandom_range(0, 5) == 0) b.op = 5'($urandom_range(27, 31));
                else                           b.op = 5'($urandom_range(0, 26));
                b.ra = 2'($urandom); b.rb = 2'($urandom);
                b.imm = 4'($urandom); b.sign = 1'($urandom);
                prog_q.push_back(b);
            end
            prog_q.push_back(hlt);
            run_and_check($sformatf("rnd%0d", r), 0, AW);
        end
        ready_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
